// File: rtl/pbs_decomp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pbs_decomp_pkg
// Brief    : Shared types, defaults and width helpers for the gadget decomposer.
// Revision : 1.0
// ============================================================================
package pbs_decomp_pkg;

    localparam int DEF_MOD_Q_W = 64;
    localparam int DEF_PBS_L   = 1;
    localparam int DEF_PBS_B_W = 23;
    localparam int DEF_CHUNK   = 4;

    localparam int DIGIT_W     = DEF_PBS_B_W + 1;
    localparam int LVL_W       = $clog2(DEF_PBS_L) + 1;
    localparam int ROUND_SHIFT = DEF_MOD_Q_W - DEF_PBS_L * DEF_PBS_B_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef logic signed [DIGIT_W-1:0] digit_t;

    // Derived widths for a non-default configuration.
    function automatic int digit_w(input int b_w);
        return b_w + 1;
    endfunction

    function automatic int lvl_w(input int l);
        return $clog2(l) + 1;
    endfunction

    function automatic int round_shift(input int q_w, input int l, input int b_w);
        return q_w - l * b_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pbs_decomp_digit.sv
`default_nettype none
// ============================================================================
// Module   : pbs_decomp_digit
// Brief    : One coefficient, one level: balanced signed digit plus carry out.
// Revision : 1.0
// ============================================================================
module pbs_decomp_digit #(
    parameter int PBS_B_W = 23
) (
    input  logic [PBS_B_W-1:0] i_slice,
    input  logic               i_cin,
    input  logic               i_next_lsb,
    output logic [PBS_B_W:0]   o_digit,
    output logic               o_cout
);

    localparam logic [PBS_B_W:0] c_half = (PBS_B_W + 1)'(1) << (PBS_B_W - 1);
    localparam logic [PBS_B_W:0] c_base = (PBS_B_W + 1)'(1) << PBS_B_W;

    logic [PBS_B_W:0] w_d;
    logic             w_wrap;

    // A tie at exactly H rounds toward an even next slice.
    always_comb begin
        w_d     = {1'b0, i_slice} + {{PBS_B_W{1'b0}}, i_cin};
        w_wrap  = (w_d > c_half) || ((w_d == c_half) && i_next_lsb);
        o_cout  = w_wrap;
        o_digit = w_wrap ? (w_d - c_base) : w_d;
    end

endmodule
`default_nettype wire

// File: rtl/pbs_gadget_decomposer.sv
`default_nettype none
// ============================================================================
// Module   : pbs_gadget_decomposer
// Brief    : Streaming signed gadget decomposer, PBS_L digits per coefficient,
//            least-significant level first. Optional PBS_DECOMP_CARRY_OUT_EN
//            exposes the final wrap carry and a sticky rounding-overflow flag.
// Revision : 1.0
// ============================================================================
module pbs_gadget_decomposer
    import pbs_decomp_pkg::*;
#(
    parameter int MOD_Q_W = DEF_MOD_Q_W,
    parameter int PBS_L   = DEF_PBS_L,
    parameter int PBS_B_W = DEF_PBS_B_W,
    parameter int CHUNK   = DEF_CHUNK
) (
    input  logic                             clk,
    input  logic                             a_rst,
    input  logic [CHUNK*MOD_Q_W-1:0]         in_data,
    input  logic                             in_vld,
    output logic                             in_rdy,
    output logic [CHUNK*(PBS_B_W+1)-1:0]     out_data,
    output logic [$clog2(PBS_L):0]           out_level,
    output logic                             out_last,
    output logic                             out_vld,
    input  logic                             out_rdy
`ifdef PBS_DECOMP_CARRY_OUT_EN
    ,
    output logic [CHUNK-1:0]                 out_carry,
    output logic                             round_ovf
`endif
);

    localparam int c_digit_w = digit_w(PBS_B_W);
    localparam int c_lvl_w   = lvl_w(PBS_L);
    localparam int c_rw      = PBS_L * PBS_B_W;
    localparam int c_shift   = round_shift(MOD_Q_W, PBS_L, PBS_B_W);

    localparam logic [c_lvl_w-1:0] c_lvl_top = c_lvl_w'(PBS_L - 1);
    localparam logic [c_lvl_w-1:0] c_lvl_one = c_lvl_w'(1);

    generate
        if (c_rw > MOD_Q_W) begin : g_bad_cfg
            $fatal(1, "pbs_gadget_decomposer: PBS_L*PBS_B_W exceeds MOD_Q_W");
        end
    endgenerate

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic                            r_live;
    logic [c_lvl_w-1:0]              r_level;
    logic                            r_last;
    logic [CHUNK-1:0][c_rw-1:0]      r_slice;
    logic [CHUNK-1:0]                r_carry;
    logic [CHUNK-1:0][c_digit_w-1:0] r_digit;

    logic [CHUNK-1:0][c_rw-1:0]      w_round;
    logic [CHUNK-1:0][c_rw-1:0]      w_src;
    logic [CHUNK-1:0][c_rw-1:0]      w_rest;
    logic [CHUNK-1:0][c_digit_w-1:0] w_digit;
    logic [CHUNK-1:0]                w_next_lsb;
    logic [CHUNK-1:0]                w_cin;
    logic [CHUNK-1:0]                w_cout;
    logic [CHUNK-1:0]                w_ovf;
    logic                            w_in_hs;
    logic                            w_out_hs;
    logic                            w_step;
    logic                            w_unused;

    assign out_vld   = (r_state == ST_RUN);
    assign out_level = r_level;
    assign out_last  = r_last;
    assign out_data  = r_digit;

    assign in_rdy   = r_live & ((r_state == ST_IDLE) |
                                ((r_state == ST_RUN) & (r_level == '0) & out_rdy));
    assign w_in_hs  = in_vld & in_rdy;
    assign w_out_hs = out_vld & out_rdy;
    assign w_step   = w_out_hs & (r_level != '0);

    // Coefficient bits below the rounding point never reach the digits.
    assign w_unused = ^{in_data, w_ovf};

    // The first level is computed straight from the rounded input so the
    // first beat is valid one cycle after the input handshake; the remaining
    // slices shift down so the active slice always sits at bit 0.
    generate
        for (genvar i = 0; i < CHUNK; i++) begin : g_lane
            if (c_shift == 0) begin : g_no_round
                assign w_round[i] = in_data[i*MOD_Q_W +: c_rw];
                assign w_ovf[i]   = 1'b0;
            end else begin : g_round
                assign w_round[i] = in_data[i*MOD_Q_W + c_shift +: c_rw]
                                  + {{(c_rw-1){1'b0}}, in_data[i*MOD_Q_W + c_shift - 1]};
                assign w_ovf[i]   = (&in_data[i*MOD_Q_W + c_shift +: c_rw])
                                  & in_data[i*MOD_Q_W + c_shift - 1];
            end

            assign w_src[i] = w_in_hs ? w_round[i] : r_slice[i];
            assign w_cin[i] = w_in_hs ? 1'b0 : r_carry[i];

            if (c_rw > PBS_B_W) begin : g_multi
                assign w_next_lsb[i] = w_src[i][PBS_B_W];
                assign w_rest[i]     = {{PBS_B_W{1'b0}}, w_src[i][c_rw-1:PBS_B_W]};
            end else begin : g_single
                assign w_next_lsb[i] = 1'b0;
                assign w_rest[i]     = '0;
            end

            pbs_decomp_digit #(
                .PBS_B_W   (PBS_B_W)
            ) u_digit (
                .i_slice    (w_src[i][PBS_B_W-1:0]),
                .i_cin      (w_cin[i]),
                .i_next_lsb (w_next_lsb[i]),
                .o_digit    (w_digit[i]),
                .o_cout     (w_cout[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_in_hs) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_out_hs && (r_level == '0) && !w_in_hs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            r_live  <= 1'b0;
            r_level <= '0;
            r_last  <= 1'b0;
            r_slice <= '0;
            r_carry <= '0;
            r_digit <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_in_hs || w_step) begin
                r_slice <= w_rest;
                r_carry <= w_cout;
                r_digit <= w_digit;
                r_level <= w_in_hs ? c_lvl_top : (r_level - c_lvl_one);
                r_last  <= w_in_hs ? (PBS_L == 1) : (r_level == c_lvl_one);
            end
        end
    end

`ifdef PBS_DECOMP_CARRY_OUT_EN
    logic r_round_ovf;

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            r_round_ovf <= 1'b0;
        end else if (w_in_hs && (|w_ovf)) begin
            r_round_ovf <= 1'b1;
        end
    end

    assign out_carry = r_carry;
    assign round_ovf = r_round_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pbs_gadget_decomposer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pbs_gadget_decomposer
// Brief    : Directed bench: L=1/B=23/CHUNK=1 and L=2/B=4/CHUNK=4 instances.
// Revision : 1.0
// ============================================================================
module tb_pbs_gadget_decomposer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         a_rst;

    logic [63:0]  a_in_data;
    logic         a_in_vld, a_in_rdy, a_out_last, a_out_vld, a_out_rdy;
    logic [23:0]  a_out_data;
    logic [0:0]   a_out_level;

    logic [255:0] b_in_data;
    logic         b_in_vld, b_in_rdy, b_out_last, b_out_vld, b_out_rdy;
    logic [19:0]  b_out_data;
    logic [1:0]   b_out_level;

`ifdef PBS_DECOMP_CARRY_OUT_EN
    logic [0:0]   a_out_carry;
    logic         a_round_ovf;
    logic [3:0]   b_out_carry;
    logic         b_round_ovf;
`endif

    pbs_gadget_decomposer #(
        .MOD_Q_W (64), .PBS_L (1), .PBS_B_W (23), .CHUNK (1)
    ) u_dut_a (
        .clk       (clk),
        .a_rst     (a_rst),
        .in_data   (a_in_data),
        .in_vld    (a_in_vld),
        .in_rdy    (a_in_rdy),
        .out_data  (a_out_data),
        .out_level (a_out_level),
        .out_last  (a_out_last),
        .out_vld   (a_out_vld),
        .out_rdy   (a_out_rdy)
`ifdef PBS_DECOMP_CARRY_OUT_EN
        ,
        .out_carry (a_out_carry),
        .round_ovf (a_round_ovf)
`endif
    );

    pbs_gadget_decomposer #(
        .MOD_Q_W (64), .PBS_L (2), .PBS_B_W (4), .CHUNK (4)
    ) u_dut_b (
        .clk       (clk),
        .a_rst     (a_rst),
        .in_data   (b_in_data),
        .in_vld    (b_in_vld),
        .in_rdy    (b_in_rdy),
        .out_data  (b_out_data),
        .out_level (b_out_level),
        .out_last  (b_out_last),
        .out_vld   (b_out_vld),
        .out_rdy   (b_out_rdy)
`ifdef PBS_DECOMP_CARRY_OUT_EN
        ,
        .out_carry (b_out_carry),
        .round_ovf (b_round_ovf)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Lane vectors, lane 0 in the low 64 bits; digits hand-derived for B=4.
    localparam logic [255:0] VEC1 = {64'h9800_0000_0000_0000, 64'h0F80_0000_0000_0000,
                                     64'h1900_0000_0000_0000, 64'h8700_0000_0000_0000};
    localparam logic [19:0]  V1_L1 = {5'h18, 5'h00, 5'h19, 5'h07};
    localparam logic [19:0]  V1_L0 = {5'h1A, 5'h01, 5'h02, 5'h08};
    localparam logic [255:0] VEC2 = {64'h7FFF_FFFF_FFFF_FFFF, 64'hFF80_0000_0000_0000,
                                     64'h2800_0000_0000_0000, 64'h1800_0000_0000_0000};
    localparam logic [19:0]  V2_L1 = {5'h00, 5'h00, 5'h08, 5'h18};
    localparam logic [19:0]  V2_L0 = {5'h08, 5'h00, 5'h02, 5'h02};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input int n, input bit rnd);
        logic [255:0]      vecs [$];
        logic [31:0]       exp_q [$];
        logic signed [4:0] d1 [4];
        logic [31:0]       r_pack;
        logic [63:0]       x;
        logic [19:0]       hold_data;
        logic [1:0]        hold_lvl;
        logic              hold_last;
        bit                stalled;
        int                sent, got, cyc, s;
        stalled = 1'b0;
        sent = 0;
        got  = 0;
        cyc  = 0;
        hold_data = '0;
        hold_lvl  = '0;
        hold_last = 1'b0;
        for (int k = 0; k < n; k++) begin
            vecs.push_back({$urandom, $urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom, $urandom});
        end
        while (got < n && cyc < 400) begin
            b_out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            b_in_vld  = (sent < n);
            b_in_data = (sent < n) ? vecs[sent] : '0;
            #1;
            if (!rnd && sent > 0 && sent < n) begin
                chk("stream_vld", b_out_vld, 1);
                chk("stream_rdy", b_in_rdy, b_out_level == 2'd0);
            end
            if (b_out_vld && b_out_rdy) begin
                if (b_out_level == 2'd1) begin
                    for (int i = 0; i < 4; i++) d1[i] = $signed(b_out_data[i*5 +: 5]);
                end else begin
                    chk("stream_last", b_out_last, 1);
                    for (int i = 0; i < 4; i++) begin
                        s = int'(d1[i]) + 16 * int'($signed(b_out_data[i*5 +: 5]));
                        chk("stream_recon", s & 255, exp_q[0][i*8 +: 8]);
                    end
                    void'(exp_q.pop_front());
                    got++;
                end
            end
            if (b_in_vld && b_in_rdy) begin
                for (int i = 0; i < 4; i++) begin
                    x = b_in_data[i*64 +: 64];
                    r_pack[i*8 +: 8] = x[63:56] + {7'd0, x[55]};
                end
                exp_q.push_back(r_pack);
                sent++;
            end
            stalled   = b_out_vld && !b_out_rdy;
            hold_data = b_out_data;
            hold_lvl  = b_out_level;
            hold_last = b_out_last;
            tick();
            cyc++;
            if (stalled) begin
                chk("stall_data", b_out_data, hold_data);
                chk("stall_lvl", b_out_level, hold_lvl);
                chk("stall_last", b_out_last, hold_last);
            end
        end
        chk("stream_count", got, n);
        b_in_vld  = 1'b0;
        b_out_rdy = 1'b1;
    endtask

    initial begin
        a_rst = 1'b1;
        a_in_data = '0; a_in_vld = 1'b0; a_out_rdy = 1'b0;
        b_in_data = '0; b_in_vld = 1'b0; b_out_rdy = 1'b0;
        tick();
        tick();
        chk("rst_a_vld", a_out_vld, 0);
        chk("rst_a_rdy", a_in_rdy, 0);
        chk("rst_a_data", a_out_data, 0);
        chk("rst_a_lvl", a_out_level, 0);
        chk("rst_a_last", a_out_last, 0);
        chk("rst_b_vld", b_out_vld, 0);
        chk("rst_b_rdy", b_in_rdy, 0);
        chk("rst_b_data", b_out_data, 0);
        a_rst = 1'b0;
        #1;
        chk("rdy_pre_edge", b_in_rdy, 0);
        tick();
        chk("rdy_post_rst_a", a_in_rdy, 1);
        chk("rdy_post_rst_b", b_in_rdy, 1);

        // L=1, B=23: single-level beats, back to back.
        a_out_rdy = 1'b1;
        a_in_data = 64'h0000_0100_0000_0000;
        a_in_vld  = 1'b1;
        tick();
        chk("a_2p40_vld", a_out_vld, 1);
        chk("a_2p40_dig", a_out_data, 24'd1);
        chk("a_2p40_lvl", a_out_level, 0);
        chk("a_2p40_last", a_out_last, 1);
        a_in_data = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("a_b2b_rdy", a_in_rdy, 1);
        tick();
        chk("a_ones_vld", a_out_vld, 1);
        chk("a_ones_dig", a_out_data, 24'd0);
        a_in_data = 64'h8000_0000_0000_0000;
        tick();
        chk("a_half_dig", a_out_data, 24'h40_0000);
        chk("a_half_last", a_out_last, 1);
        a_out_rdy = 1'b0;
        a_in_data = 64'h0000_0100_0000_0000;
        #1;
        chk("a_stall_rdy", a_in_rdy, 0);
        tick();
        chk("a_stall_dig1", a_out_data, 24'h40_0000);
        tick();
        chk("a_stall_dig2", a_out_data, 24'h40_0000);
        chk("a_stall_vld", a_out_vld, 1);
        a_out_rdy = 1'b1;
        a_in_vld  = 1'b0;
        tick();
        chk("a_idle_vld", a_out_vld, 0);

        // L=2, B=4, CHUNK=4: two levels, ties and negative digits.
        b_out_rdy = 1'b1;
        b_in_data = VEC1;
        b_in_vld  = 1'b1;
        tick();
        chk("b1_l1_vld", b_out_vld, 1);
        chk("b1_l1_lvl", b_out_level, 1);
        chk("b1_l1_last", b_out_last, 0);
        chk("b1_l1_dig", b_out_data, V1_L1);
        b_in_data = VEC2;
        #1;
        chk("b1_l1_rdy", b_in_rdy, 0);
        tick();
        chk("b1_l0_lvl", b_out_level, 0);
        chk("b1_l0_last", b_out_last, 1);
        chk("b1_l0_dig", b_out_data, V1_L0);
        chk("b1_l0_rdy", b_in_rdy, 1);
        tick();
        chk("b2_l1_lvl", b_out_level, 1);
        chk("b2_l1_dig", b_out_data, V2_L1);
        b_in_vld = 1'b0;
        tick();
        chk("b2_l0_dig", b_out_data, V2_L0);
        chk("b2_l0_last", b_out_last, 1);
        tick();
        chk("b_idle_vld", b_out_vld, 0);

        // Output stall at level 1.
        b_in_data = VEC1;
        b_in_vld  = 1'b1;
        b_out_rdy = 1'b0;
        tick();
        b_in_vld = 1'b0;
        tick();
        chk("b_stall_lvl", b_out_level, 1);
        chk("b_stall_dig", b_out_data, V1_L1);
        b_out_rdy = 1'b1;
        tick();
        chk("b_unstall_dig", b_out_data, V1_L0);
        tick();
        chk("b_unstall_idle", b_out_vld, 0);

        // Reset while in RUN at level 1, then a clean restart.
        b_in_data = VEC2;
        b_in_vld  = 1'b1;
        b_out_rdy = 1'b0;
        tick();
        chk("b_pre_rst_lvl", b_out_level, 1);
        b_in_vld = 1'b0;
        a_rst = 1'b1;
        tick();
        chk("b_rst_vld", b_out_vld, 0);
        chk("b_rst_dig", b_out_data, 0);
        a_rst = 1'b0;
        tick();
        chk("b_rst_rdy", b_in_rdy, 1);
        b_out_rdy = 1'b1;
        b_in_data = VEC1;
        b_in_vld  = 1'b1;
        tick();
        chk("b_post_l1_lvl", b_out_level, 1);
        chk("b_post_l1_dig", b_out_data, V1_L1);
        b_in_vld = 1'b0;
        tick();
        chk("b_post_l0_dig", b_out_data, V1_L0);
        tick();

        run_stream(6, 1'b0);
        tick();
        run_stream(10, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
